alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream issue/writeback stage for the registered 32-bit ALU. Accepts op requests (valid/ready),
//  reads operands from an internal register file, and drives A/B/ALUControl. It captures ALUOut,
//  High/Low and flags one clock after the ALU samples them, writes the result back to regs/HI/LO,
//  and reports status. Ops are strictly serialised: one in flight, 3 clocks accept-to-writeback.
// PARAMETERS
//  NREGS   8   register-file depth; r0 reads 0 and ignores writes
//  RAW     3   register index width, clog2(NREGS)
// PORTS
//  clk          in   1     single clock, all state on posedge
//  rst_n        in   1     asynchronous, active-low reset
//  req_valid    in   1     op request valid
//  req_ready    out  1     high only in IDLE
//  req_op       in   3     ALU select: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 mul, 110 div, 111 illegal
//  req_rd/rs/rt in   RAW   dest / src-A / src-B register index
//  ld_en        in   1     host register load strobe
//  ld_addr      in   RAW   host load index
//  ld_data      in   32    host load data
//  dbg_addr     in   RAW   debug read index
//  dbg_data     out  32    combinational read of reg[dbg_addr]
//  alu_a, alu_b out  32    registered ALU operands
//  alu_ctrl     out  3     registered ALUControl
//  alu_out      in   32    ALU result (ALUOut)
//  alu_high/low in   32    ALU High/Low
//  alu_zero/carry/ovf/divzero in 1  ALU flags
//  hi_q, lo_q   out  32    architectural HI/LO
//  done         out  1     1-cycle pulse when an op retires
//  st_flags     out  5     {illegal, divzero, ovf, carry, zero} of the last retired op, held until next retire
//  err_sticky   out  1     set by divide-by-zero or illegal op; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; all regs, hi_q, lo_q, alu_a, alu_b, alu_ctrl, st_flags, done, err_sticky = 0.
//   Reset mid-op aborts the op with no writeback; req_ready=1 on the first clock after release.
//  FSM IDLE->ISSUE->CAPTURE->IDLE.
//  IDLE: on req_valid&&req_ready (edge E0), latch op/rd, load alu_a=reg[rs], alu_b=reg[rt],
//   alu_ctrl=op, then go to ISSUE. Op 111 goes straight to CAPTURE with no ALU use.
//  ISSUE: ALU samples the operands at E1; go to CAPTURE.
//  CAPTURE: the ALU outputs are stable. At E2 perform writeback and st_flags update, done=1 for the
//   following cycle, then go to IDLE. A new request can be accepted at E3 at the earliest.
//  Writeback by op:
//   000-100: reg[rd]=alu_out; zero=alu_zero; carry,ovf = alu_carry,alu_ovf for 000/001, else 0.
//   101: hi_q=alu_high, lo_q=alu_low, reg[rd]=alu_low; ovf=alu_ovf; zero=(alu_low==0); carry=0.
//   110, alu_divzero=0: hi_q=alu_high (quotient), lo_q=alu_low (remainder), reg[rd]=alu_high;
//    zero=(alu_high==0).
//   110, alu_divzero=1: no reg/HI/LO write; divzero=1; err_sticky=1.
//   111: no writes; illegal=1; err_sticky=1.
//  rd=0: write suppressed; st_flags and HI/LO still update.
//  ld_en: writes reg[ld_addr] at the edge, in any state.
//   A writeback to the same index in the same cycle wins over ld_en.
//   An ld_en to rs/rt in the accept cycle is not seen; the operand takes the pre-edge value.
//  req_valid outside IDLE is ignored; no queueing. Unsigned 32-bit arithmetic; no width growth.
// TESTING
//  ld r1=5, r2=7; ADD rd=3 -> r3=12, done 3 clks after accept, st_flags=00000.
//  ld r1=0, r2=1; SUB rd=4 -> r4=0xFFFFFFFF, carry=1, zero=0.
//  r1=r2=0x00010000; MUL rd=5 -> hi_q=1, lo_q=0, r5=0, ovf=1, zero=1.
//  r1=17, r2=5: DIV rd=6 -> r6=3, hi_q=3, lo_q=2. Then r2=0: DIV -> r6/HI/LO unchanged,
//   divzero=1, err_sticky=1.
//  Op 111 and ADD with rd=0 -> no reg writes, done pulses; illegal=1 on the 111 op only.
//  Assert rst_n low during ISSUE -> every output 0, no writeback, req_ready=1 after release;
//   back-to-back requests accepted every 3 clks.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer for an external registered 32-bit ALU, with its own register file and HI/LO.
// Serialises ops, one in flight: accept, issue, capture/writeback; an illegal op skips the issue clock.
module alu_op_sequencer #(
  parameter int NREGS = 8,
  parameter int RAW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [RAW-1:0]  req_rd,
  input  logic [RAW-1:0]  req_rs,
  input  logic [RAW-1:0]  req_rt,
  input  logic            ld_en,
  input  logic [RAW-1:0]  ld_addr,
  input  logic [31:0]     ld_data,
  input  logic [RAW-1:0]  dbg_addr,
  output logic [31:0]     dbg_data,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [31:0]     alu_out,
  input  logic [31:0]     alu_high,
  input  logic [31:0]     alu_low,
  input  logic            alu_zero,
  input  logic            alu_carry,
  input  logic            alu_ovf,
  input  logic            alu_divzero,
  output logic [31:0]     hi_q,
  output logic [31:0]     lo_q,
  output logic            done,
  output logic [4:0]      st_flags,
  output logic            err_sticky
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  // Everything the retiring op does, decoded from the op and the captured ALU outputs.
  typedef struct packed {
    logic        reg_en;
    logic [31:0] reg_dat;
    logic        hilo_en;
    logic [31:0] hi_dat;
    logic [31:0] lo_dat;
    logic [4:0]  flags;
    logic        err;
  } wb_t;

  state_t         state_q;
  state_t         state_d;
  logic [2:0]     op_q;
  logic [RAW-1:0] rd_q;
  logic [31:0]    regs_q [NREGS];
  logic           accept;
  logic           wb_fire;
  wb_t            wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    wb_fire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (req_op == OP_ILL) ? S_CAPTURE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        wb_fire = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Flags are {illegal, divzero, ovf, carry, zero}.
  always_comb begin
    wb = '0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        wb.reg_en  = 1'b1;
        wb.reg_dat = alu_out;
        wb.flags   = {2'b00, alu_ovf, alu_carry, alu_zero};
      end
      OP_AND, OP_OR, OP_SLT: begin
        wb.reg_en  = 1'b1;
        wb.reg_dat = alu_out;
        wb.flags   = {4'b0000, alu_zero};
      end
      OP_MUL: begin
        wb.reg_en  = 1'b1;
        wb.reg_dat = alu_low;
        wb.hilo_en = 1'b1;
        wb.hi_dat  = alu_high;
        wb.lo_dat  = alu_low;
        wb.flags   = {2'b00, alu_ovf, 1'b0, (alu_low == 32'd0)};
      end
      OP_DIV: begin
        if (alu_divzero) begin
          wb.flags = 5'b01000;
          wb.err   = 1'b1;
        end else begin
          wb.reg_en  = 1'b1;
          wb.reg_dat = alu_high;
          wb.hilo_en = 1'b1;
          wb.hi_dat  = alu_high;
          wb.lo_dat  = alu_low;
          wb.flags   = {4'b0000, (alu_high == 32'd0)};
        end
      end
      OP_ILL: begin
        wb.flags = 5'b10000;
        wb.err   = 1'b1;
      end
      default: begin
        wb = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rd_q     <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
    end else if (accept) begin
      op_q     <= req_op;
      rd_q     <= req_rd;
      alu_a    <= regs_q[req_rs];
      alu_b    <= regs_q[req_rt];
      alu_ctrl <= req_op;
    end
  end

  // Writeback is the later assignment, so it beats a host load to the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (ld_en && (ld_addr != '0)) begin
        regs_q[ld_addr] <= ld_data;
      end
      if (wb_fire && wb.reg_en && (rd_q != '0)) begin
        regs_q[rd_q] <= wb.reg_dat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q       <= '0;
      lo_q       <= '0;
      st_flags   <= '0;
      done       <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      done <= wb_fire;
      if (wb_fire) begin
        st_flags <= wb.flags;
        if (wb.hilo_en) begin
          hi_q <= wb.hi_dat;
          lo_q <= wb.lo_dat;
        end
        if (wb.err) begin
          err_sticky <= 1'b1;
        end
      end
    end
  end

  assign dbg_data = regs_q[dbg_addr];

endmodule
